// File: rtl/half_duplex_uart_host.sv
// Host-side sequencer for the half-duplex UART interface: bridges valid/ready TX and RX
// byte streams onto the interface strobes, with RX-first turnaround, TX guard time and RX timeout.
module half_duplex_uart_host #(
    parameter int GUARD_CYCLES  = 16,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic [7:0]               txData,
    input  logic                     txValid,
    output logic                     txReady,
    output logic [7:0]               rxData,
    output logic                     rxFrameErr,
    output logic                     rxOverrun,
    output logic                     rxValid,
    input  logic                     rxReady,
    input  logic [TIMEOUT_WIDTH-1:0] waitCycles,
    output logic                     rxTimeout,
    output logic                     busy,
    output logic [7:0]               uartDataIn,
    output logic                     uartNWe,
    input  logic [7:0]               uartDataOut,
    output logic                     uartNCsData,
    input  logic [7:0]               uartStatus,
    output logic                     uartNCsStatus
);
    localparam int TW = TIMEOUT_WIDTH;
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LAST = (GUARD_CYCLES > 0) ? GW'(GUARD_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE, TX_WR, TX_CHK, TX_WAIT, GUARD, RX_HOLD, RX_ACK, RX_CLR
    } state_t;

    state_t        state, stateNext;
    logic [7:0]    uartDataInNext, rxDataNext;
    logic          uartNWeNext, uartNCsDataNext;
    logic          rxFrameErrNext, rxOverrunNext, rxValidNext, rxTimeoutNext;
    logic          retry, retryNext;
    logic [GW-1:0] guardCnt, guardCntNext;
    logic [TW-1:0] toCnt, toCntNext;
    logic          toCount;

    logic txRun, txPending, rxRun, rxStartBit, bufferFull, rxHas, lineIdle;
    logic unusedIsTx;

    assign txRun         = uartStatus[7];
    assign txPending     = uartStatus[6];
    assign rxRun         = uartStatus[5];
    assign rxStartBit    = uartStatus[4];
    assign bufferFull    = uartStatus[0];
    assign unusedIsTx    = uartStatus[3];
    assign rxHas         = bufferFull & ~txPending & ~txRun;
    assign lineIdle      = (uartStatus[7:4] == 4'b0000) & ~bufferFull;

    assign txReady       = (state == IDLE) & ~rxHas & lineIdle & ~retry;
    assign busy          = (state != IDLE);
    assign uartNCsStatus = 1'b0;

    // A write dropped by a concurrent RX leaves retry set; uartDataIn is kept for the resend.
    always_comb begin
        stateNext       = state;
        uartDataInNext  = uartDataIn;
        uartNWeNext     = 1'b1;
        uartNCsDataNext = 1'b1;
        rxDataNext      = rxData;
        rxFrameErrNext  = rxFrameErr;
        rxOverrunNext   = rxOverrun;
        rxValidNext     = rxValid;
        retryNext       = retry;
        guardCntNext    = guardCnt;
        case (state)
            IDLE: begin
                if (rxHas) begin
                    rxDataNext     = uartDataOut;
                    rxOverrunNext  = uartStatus[2];
                    rxFrameErrNext = uartStatus[1];
                    rxValidNext    = 1'b1;
                    stateNext      = RX_HOLD;
                end else if (retry && lineIdle) begin
                    uartNWeNext = 1'b0;
                    stateNext   = TX_WR;
                end else if (txValid && txReady) begin
                    uartDataInNext = txData;
                    uartNWeNext    = 1'b0;
                    stateNext      = TX_WR;
                end
            end
            TX_WR:   stateNext = TX_CHK;
            TX_CHK: begin
                if (txPending || txRun) begin
                    retryNext = 1'b0;
                    stateNext = TX_WAIT;
                end else begin
                    retryNext = 1'b1;
                    stateNext = IDLE;
                end
            end
            TX_WAIT: begin
                if (!txRun && !txPending) begin
                    guardCntNext = '0;
                    stateNext    = (GUARD_CYCLES == 0) ? IDLE : GUARD;
                end
            end
            GUARD: begin
                if (guardCnt == GUARD_LAST) stateNext = IDLE;
                else guardCntNext = guardCnt + GW'(1);
            end
            RX_HOLD: begin
                if (rxReady) begin
                    rxValidNext     = 1'b0;
                    uartNCsDataNext = 1'b0;
                    stateNext       = RX_ACK;
                end
            end
            RX_ACK:  stateNext = RX_CLR;
            RX_CLR:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Character-wait timer runs only while idle with a quiet receiver; it wraps after each pulse.
    always_comb begin
        toCount       = (state == IDLE) && (stateNext == IDLE) && (waitCycles != '0)
                        && !rxRun && !rxStartBit;
        rxTimeoutNext = 1'b0;
        toCntNext     = '0;
        if (toCount) begin
            if (toCnt >= waitCycles - TW'(1)) begin
                rxTimeoutNext = 1'b1;
                toCntNext     = '0;
            end else if (toCnt != '1) begin
                toCntNext = toCnt + TW'(1);
            end else begin
                toCntNext = toCnt;
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            uartDataIn  <= '0;
            uartNWe     <= 1'b1;
            uartNCsData <= 1'b1;
            rxData      <= '0;
            rxFrameErr  <= 1'b0;
            rxOverrun   <= 1'b0;
            rxValid     <= 1'b0;
            rxTimeout   <= 1'b0;
            retry       <= 1'b0;
            guardCnt    <= '0;
            toCnt       <= '0;
        end else begin
            state       <= stateNext;
            uartDataIn  <= uartDataInNext;
            uartNWe     <= uartNWeNext;
            uartNCsData <= uartNCsDataNext;
            rxData      <= rxDataNext;
            rxFrameErr  <= rxFrameErrNext;
            rxOverrun   <= rxOverrunNext;
            rxValid     <= rxValidNext;
            rxTimeout   <= rxTimeoutNext;
            retry       <= retryNext;
            guardCnt    <= guardCntNext;
            toCnt       <= toCntNext;
        end
    end
endmodule

// File: tb/tb_half_duplex_uart_host.sv
// Bench for half_duplex_uart_host: a table of TX/RX transactions checked through queue
// scoreboards, plus hand-built retry, timeout and reset sequences.
module tb_half_duplex_uart_host;
    localparam int GUARD_CYCLES = 16;
    localparam int TW = 16;

    logic          clk;
    logic          nReset;
    logic [7:0]    txData;
    logic          txValid;
    logic          txReady;
    logic [7:0]    rxData;
    logic          rxFrameErr;
    logic          rxOverrun;
    logic          rxValid;
    logic          rxReady;
    logic [TW-1:0] waitCycles;
    logic          rxTimeout;
    logic          busy;
    logic [7:0]    uartDataIn;
    logic          uartNWe;
    logic [7:0]    uartDataOut;
    logic          uartNCsData;
    logic [7:0]    uartStatus;
    logic          uartNCsStatus;

    half_duplex_uart_host #(.GUARD_CYCLES(GUARD_CYCLES), .TIMEOUT_WIDTH(TW)) dut (
        .clk(clk), .nReset(nReset),
        .txData(txData), .txValid(txValid), .txReady(txReady),
        .rxData(rxData), .rxFrameErr(rxFrameErr), .rxOverrun(rxOverrun),
        .rxValid(rxValid), .rxReady(rxReady),
        .waitCycles(waitCycles), .rxTimeout(rxTimeout), .busy(busy),
        .uartDataIn(uartDataIn), .uartNWe(uartNWe), .uartDataOut(uartDataOut),
        .uartNCsData(uartNCsData), .uartStatus(uartStatus), .uartNCsStatus(uartNCsStatus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       isTx;
        logic [7:0] status;
        logic [7:0] data;
        int         holdCycles;
        logic       txDuringHold;
        logic [7:0] expData;
        logic       expOvr;
        logic       expFe;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       ovr;
        logic       fe;
    } rxExp_t;

    vec_t       vecs[6];
    logic [7:0] txQ[$];
    rxExp_t     rxQ[$];
    rxExp_t     rxExpCur;
    int         pulses[$];

    int   compared    = 0;
    int   mismatched  = 0;
    int   nWeLows     = 0;
    int   nCsLows     = 0;
    int   readyLeaks  = 0;
    int   glitches    = 0;
    logic watchReady  = 1'b0;
    logic watchGlitch = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Every write strobe must carry the next byte the scoreboard expects.
    always @(negedge clk) begin
        if (nReset && !uartNWe) begin
            nWeLows++;
            if (txQ.size() == 0) checkOutput("txQueueUnderflow", txQ.size(), 1);
            else checkOutput("uartDataIn", uartDataIn, txQ.pop_front());
        end
        if (nReset && rxValid && rxReady) begin
            if (rxQ.size() == 0) begin
                checkOutput("rxQueueUnderflow", rxQ.size(), 1);
            end else begin
                rxExpCur = rxQ.pop_front();
                checkOutput("rxData", rxData, rxExpCur.data);
                checkOutput("rxOverrun", rxOverrun, rxExpCur.ovr);
                checkOutput("rxFrameErr", rxFrameErr, rxExpCur.fe);
            end
        end
        if (nReset && !uartNCsData) nCsLows++;
        if (watchReady && txReady) readyLeaks++;
    end

    always @(negedge uartNWe or negedge uartNCsData) begin
        if (watchGlitch) glitches++;
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_uartNWe"}, uartNWe, 1);
        checkOutput({tag, "_uartNCsData"}, uartNCsData, 1);
        checkOutput({tag, "_uartNCsStatus"}, uartNCsStatus, 0);
        checkOutput({tag, "_uartDataIn"}, uartDataIn, 0);
        checkOutput({tag, "_rxData"}, rxData, 0);
        checkOutput({tag, "_rxFlags"}, {rxOverrun, rxFrameErr}, 0);
        checkOutput({tag, "_rxValid"}, rxValid, 0);
        checkOutput({tag, "_rxTimeout"}, rxTimeout, 0);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    // Entered at the negedge showing the write strobe; plays the UART busy sending, then idle.
    // txReady stays low for the TX_WAIT cycle that observes the idle line plus the guard time.
    task automatic finishTx();
        int lowCnt;
        lowCnt = 0;
        @(posedge clk); #1 uartStatus = 8'hC8;
        repeat (4) begin
            @(negedge clk);
            checkOutput("txReadyDuringRun", txReady, 0);
        end
        @(posedge clk); #1 uartStatus = 8'h00;
        while (lowCnt < 100) begin
            @(negedge clk);
            if (txReady) break;
            lowCnt++;
        end
        checkOutput("guardLength", lowCnt, GUARD_CYCLES + 1);
    endtask

    task automatic doTx(input logic [7:0] d, input logic [7:0] expByte);
        nWeLows = 0;
        @(posedge clk); #1;
        txData  = d;
        txValid = 1'b1;
        txQ.push_back(expByte);
        @(negedge clk);
        checkOutput("txReadyIdle", txReady, 1);
        @(posedge clk); #1;
        txValid = 1'b0;
        txData  = ~d;
        @(negedge clk);
        checkOutput("txBusy", busy, 1);
        finishTx();
        checkOutput("txWriteCount", nWeLows, 1);
    endtask

    // Consumer accepts, then the UART clears bufferFull after seeing the nCs strobe.
    task automatic acceptRx();
        nCsLows = 0;
        @(posedge clk); #1 rxReady = 1'b1;
        @(posedge clk); #1 rxReady = 1'b0;
        @(posedge clk); #1 uartStatus = 8'h00;
        @(posedge clk); #1;
        checkOutput("nCsPulse", nCsLows, 1);
        checkOutput("rxValidCleared", rxValid, 0);
    endtask

    task automatic doRx(input vec_t v);
        rxExp_t e;
        nWeLows    = 0;
        readyLeaks = 0;
        @(posedge clk); #1;
        uartDataOut = v.data;
        uartStatus  = v.status;
        e.data = v.expData;
        e.ovr  = v.expOvr;
        e.fe   = v.expFe;
        rxQ.push_back(e);
        watchReady = 1'b1;
        if (v.txDuringHold) begin
            txData  = 8'h99;
            txValid = 1'b1;
        end
        @(negedge clk);
        checkOutput("rxLatencyPre", rxValid, 0);
        @(negedge clk);
        checkOutput("rxLatency", rxValid, 1);
        uartDataOut = ~v.data;
        repeat (v.holdCycles) @(negedge clk);
        checkOutput("rxHoldValid", rxValid, 1);
        checkOutput("rxHoldData", rxData, v.expData);
        checkOutput("rxHoldFlags", {rxOverrun, rxFrameErr}, {v.expOvr, v.expFe});
        txValid = 1'b0;
        acceptRx();
        watchReady = 1'b0;
        checkOutput("rxNoTxReady", readyLeaks, 0);
        checkOutput("rxNoWrite", nWeLows, 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.isTx) doTx(v.data, v.expData);
        else doRx(v);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, compared %0d", compared);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rxExp_t e;
        int p0, p1;
        nReset      = 1'b0;
        txData      = 8'h00;
        txValid     = 1'b0;
        rxReady     = 1'b0;
        waitCycles  = '0;
        uartDataOut = 8'h00;
        uartStatus  = 8'h00;

        //           isTx  status  data   hold  txHold expData ovr   fe
        vecs[0] = '{1'b1, 8'h00, 8'h3B, 0,  1'b0, 8'h3B, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h01, 8'hA5, 10, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h05, 8'h3C, 3,  1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'h03, 8'h5A, 2,  1'b0, 8'h5A, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 8'h00, 8'hC4, 0,  1'b0, 8'hC4, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h07, 8'hFF, 1,  1'b1, 8'hFF, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        checkOutput("resetTxReady", txReady, 1);
        @(posedge clk); #1 nReset = 1'b1;

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Write dropped because RX won: drain RX, then the held byte is re-written.
        $display("[TB] retry sequence");
        nWeLows    = 0;
        readyLeaks = 0;
        @(posedge clk); #1;
        txData  = 8'h5C;
        txValid = 1'b1;
        txQ.push_back(8'h5C);
        txQ.push_back(8'h5C);
        @(posedge clk); #1;
        txValid     = 1'b0;
        txData      = 8'hFF;
        uartStatus  = 8'h01;
        uartDataOut = 8'h77;
        e.data = 8'h77;
        e.ovr  = 1'b0;
        e.fe   = 1'b0;
        rxQ.push_back(e);
        watchReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rxValid) break;
        end
        checkOutput("retryRxValid", rxValid, 1);
        acceptRx();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!uartNWe) break;
        end
        watchReady = 1'b0;
        checkOutput("retryRewrite", uartNWe, 0);
        checkOutput("retryNoReady", readyLeaks, 0);
        finishTx();
        checkOutput("retryWriteCount", nWeLows, 2);

        // Free-running timeout: the registered pulse lands 100 cycles after counting starts.
        $display("[TB] timeout sequence");
        @(posedge clk); #1 waitCycles = TW'(100);
        pulses.delete();
        for (int n = 1; n <= 205; n++) begin
            @(negedge clk);
            if (rxTimeout) pulses.push_back(n);
        end
        p0 = (pulses.size() > 0) ? pulses[0] : -1;
        p1 = (pulses.size() > 1) ? pulses[1] : -1;
        checkOutput("toPulseCount", pulses.size(), 2);
        checkOutput("toFirstPulse", p0, 101);
        checkOutput("toSecondPulse", p1, 201);

        @(posedge clk); #1 waitCycles = '0;
        @(posedge clk); #1 waitCycles = TW'(100);
        pulses.delete();
        for (int n = 1; n <= 160; n++) begin
            @(negedge clk);
            if (rxTimeout) pulses.push_back(n);
            if (n == 50) uartStatus = 8'h20;
            if (n == 51) uartStatus = 8'h00;
        end
        p0 = (pulses.size() > 0) ? pulses[0] : -1;
        checkOutput("toRestartCount", pulses.size(), 1);
        checkOutput("toRestartPulse", p0, 151);
        @(posedge clk); #1 waitCycles = '0;

        // Reset while waiting for the transmitter to finish.
        $display("[TB] reset sequences");
        nWeLows  = 0;
        glitches = 0;
        @(posedge clk); #1;
        txData  = 8'h81;
        txValid = 1'b1;
        txQ.push_back(8'h81);
        @(posedge clk); #1 txValid = 1'b0;
        @(posedge clk); #1 uartStatus = 8'hC8;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("txWaitBusy", busy, 1);
        #2;
        watchGlitch = 1'b1;
        nReset = 1'b0;
        #1;
        checkResetValues("rstTxWait");
        uartStatus = 8'h00;
        @(posedge clk); #1 nReset = 1'b1;
        @(negedge clk);
        checkResetValues("postRstTxWait");
        checkOutput("postRstTxReady", txReady, 1);
        watchGlitch = 1'b0;
        checkOutput("rstGlitchTx", glitches, 0);

        // Reset while holding an RX byte with a dropped write pending: the retry is discarded.
        nWeLows  = 0;
        glitches = 0;
        @(posedge clk); #1;
        txData  = 8'h42;
        txValid = 1'b1;
        txQ.push_back(8'h42);
        @(posedge clk); #1;
        txValid     = 1'b0;
        uartStatus  = 8'h01;
        uartDataOut = 8'hE7;
        repeat (4) @(negedge clk);
        checkOutput("rxHoldBeforeReset", rxValid, 1);
        #2;
        watchGlitch = 1'b1;
        nReset = 1'b0;
        #1;
        checkResetValues("rstRxHold");
        uartStatus = 8'h00;
        @(posedge clk); #1 nReset = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("retryDiscarded", nWeLows, 1);
        checkOutput("postRstRxReady", txReady, 1);
        watchGlitch = 1'b0;
        checkOutput("rstGlitchRx", glitches, 0);

        checkOutput("txQueueEmpty", txQ.size(), 0);
        checkOutput("rxQueueEmpty", rxQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
